line_buf_window_ctrl: RTL and testbench

// Sequences the two-line shift RAM and 3x3 window stage for one video stream.

---
 rtl/line_buf_window_ctrl.sv | 153 +++++++++++++++
 tb/tb_line_buf_window_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_window_ctrl.sv
// line_buf_window_ctrl: frame/line/pixel sequencer that feeds a two-line
// shift RAM and a 3x3 window stage, with border flags and frame status.
module line_buf_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10,
  parameter int RW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pre_frame_vsync,
  input  logic          pre_frame_hsync,
  input  logic          pre_frame_clken,
  output logic          line_clken,
  output logic          line_hsync,
  output logic [CW-1:0] col_cnt,
  output logic [RW-1:0] row_cnt,
  output logic          win_valid,
  output logic          edge_top,
  output logic          edge_bot,
  output logic          edge_left,
  output logic          edge_right,
  output logic          frame_start,
  output logic          frame_done,
  output logic          frame_abort,
  output logic          line_err
);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

  // Column counter is one bit wider than the output so it can hold IMG_W
  // and detect overlong lines.
  localparam logic [CW:0]   COL_MAX  = (CW+1)'(IMG_W);
  localparam logic [CW:0]   COL_LAST = (CW+1)'(IMG_W-1);
  localparam logic [CW:0]   COL_ONE  = (CW+1)'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  state_t        state;
  logic          vs_q, hs_q, armed;
  logic [CW:0]   col;
  logic [RW-1:0] row;

  logic vs_rise, vs_fall, hs_fall, running, in_frame, pix, accept, drop;
  logic short_line, last_pix, first_pix, win;

  assign vs_rise  = pre_frame_vsync & ~vs_q;
  assign vs_fall  = ~pre_frame_vsync & vs_q;
  assign hs_fall  = hs_q & ~pre_frame_hsync;
  assign running  = (state == FILL) || (state == ACTIVE);
  // A vsync rise counts as in-frame in the same cycle so that a line whose
  // hsync coincides with the rise is captured as row 0.
  assign in_frame = pre_frame_vsync & (running | ((state == IDLE) & vs_rise));
  assign pix      = in_frame & pre_frame_hsync & pre_frame_clken;
  assign accept   = pix & (col < COL_MAX);
  assign drop     = pix & ~(col < COL_MAX);
  // Only lines that actually delivered pixels are judged for length.
  assign short_line = running & hs_fall & (col != '0) & (col < COL_MAX);
  assign last_pix   = accept & (row == ROW_LAST) & (col == COL_LAST);
  assign first_pix  = accept & (armed | (state == IDLE));
  assign win        = accept & (row != '0) & (col != '0);

  // Frame FSM, position counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vs_q        <= 1'b1;  // vsync held high across reset is not a fresh rise
      hs_q        <= 1'b0;
      armed       <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_clken  <= 1'b0;
      line_hsync  <= 1'b0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      win_valid   <= 1'b0;
      edge_top    <= 1'b0;
      edge_bot    <= 1'b0;
      edge_left   <= 1'b0;
      edge_right  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      vs_q        <= pre_frame_vsync;
      hs_q        <= pre_frame_hsync;
      line_hsync  <= pre_frame_hsync;
      line_clken  <= accept;
      win_valid   <= win;
      edge_top    <= win & (row == ROW_ONE);
      edge_bot    <= win & ((row - ROW_ONE) == ROW_LAST);
      edge_left   <= win & (col == COL_ONE);
      edge_right  <= win & ((col - COL_ONE) == COL_LAST);
      frame_start <= first_pix;
      frame_done  <= last_pix;
      frame_abort <= 1'b0;
      armed       <= armed & ~accept;

      if (accept) begin
        col_cnt <= col[CW-1:0];
        row_cnt <= row;
      end

      if (first_pix)               line_err <= 1'b0;
      else if (drop || short_line) line_err <= 1'b1;

      // Line end clears the column even if a new line starts next cycle.
      if (hs_fall)     col <= '0;
      else if (accept) col <= col + COL_ONE;

      if (hs_fall && (col != '0) && (row != ROW_LAST)) row <= row + ROW_ONE;

      case (state)
        IDLE: if (vs_rise) begin
          state <= FILL;
          armed <= ~accept;
        end
        FILL: begin
          if (vs_fall) begin
            state       <= IDLE;
            frame_abort <= 1'b1;
            armed       <= 1'b0;
            col         <= '0;
            row         <= '0;
          end else if (last_pix) begin
            state <= DONE;
          end else if (hs_fall && (col != '0) && (row == ROW_ONE)) begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (vs_fall) begin
            state       <= IDLE;
            frame_abort <= 1'b1;
            armed       <= 1'b0;
            col         <= '0;
            row         <= '0;
          end else if (last_pix) begin
            state <= DONE;
          end
        end
        DONE: if (!pre_frame_vsync) begin
          state <= IDLE;
          col   <= '0;
          row   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buf_window_ctrl.sv
// Directed bench for line_buf_window_ctrl on an 8x4 image.
module tb_line_buf_window_ctrl;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int CW    = 3;
  localparam int RW    = 2;

  logic          clk = 1'b0;
  logic          rst, vsync, hsync, clken;
  logic          line_clken, line_hsync, win_valid;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          edge_top, edge_bot, edge_left, edge_right;
  logic          frame_start, frame_done, frame_abort, line_err;

  int total = 0;
  int bad   = 0;

  // running event counters sampled away from the active edge
  int n_clk = 0, n_win = 0, n_fs = 0, n_fd = 0, n_ab = 0;
  int n_top = 0, n_bot = 0, n_left = 0, n_right = 0;
  int n_win_bad = 0, n_edge_bad = 0;
  int done_r = -1, done_c = -1;
  int s_clk, s_win, s_fs, s_fd, s_ab, s_top, s_bot, s_left, s_right;

  line_buf_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .pre_frame_vsync(vsync), .pre_frame_hsync(hsync), .pre_frame_clken(clken),
    .line_clken(line_clken), .line_hsync(line_hsync),
    .col_cnt(col_cnt), .row_cnt(row_cnt), .win_valid(win_valid),
    .edge_top(edge_top), .edge_bot(edge_bot),
    .edge_left(edge_left), .edge_right(edge_right),
    .frame_start(frame_start), .frame_done(frame_done),
    .frame_abort(frame_abort), .line_err(line_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_clken)  n_clk++;
    if (win_valid)   n_win++;
    if (frame_start) n_fs++;
    if (frame_abort) n_ab++;
    if (edge_top)    n_top++;
    if (edge_bot)    n_bot++;
    if (edge_left)   n_left++;
    if (edge_right)  n_right++;
    if (win_valid && !line_clken) n_win_bad++;
    if (!win_valid && (edge_top || edge_bot || edge_left || edge_right)) n_edge_bad++;
    if (frame_done) begin
      n_fd++;
      done_r = row_cnt;
      done_c = col_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_clk = n_clk; s_win = n_win; s_fs = n_fs; s_fd = n_fd; s_ab = n_ab;
    s_top = n_top; s_bot = n_bot; s_left = n_left; s_right = n_right;
    done_r = -1; done_c = -1;
  endtask

  // n accepted-candidate beats, each followed by gap idle beats, then hsync low
  task automatic send_line(input int n, input int gap);
    hsync = 1'b1;
    for (int i = 0; i < n; i++) begin
      clken = 1'b1;
      tick();
      clken = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
    clken = 1'b0;
    hsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic end_frame();
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_full(input string tag);
    chk({tag, "_clken"}, n_clk - s_clk, 32);
    chk({tag, "_win"},   n_win - s_win, 21);
    chk({tag, "_fs"},    n_fs - s_fs, 1);
    chk({tag, "_fd"},    n_fd - s_fd, 1);
    chk({tag, "_done_rc"}, done_r * 16 + done_c, 3 * 16 + 7);
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; clken = 1'b0;
    tick(); tick();
    chk("reset_outs", {line_clken, line_hsync, col_cnt, row_cnt, win_valid,
                       edge_top, edge_bot, edge_left, edge_right,
                       frame_start, frame_done, frame_abort, line_err}, 0);
    rst = 1'b0;
    tick();

    // line_hsync follows hsync by one cycle even when idle
    hsync = 1'b1; tick();
    chk("hsync_idle_hi", line_hsync, 1);
    hsync = 1'b0; tick();
    chk("hsync_idle_lo", line_hsync, 0);
    chk("idle_no_clken", n_clk, 0);

    // clean frame; vsync rises together with the first hsync
    snap();
    vsync = 1'b1;
    for (int l = 0; l < 4; l++) send_line(8, 0);
    end_frame();
    check_full("clean");
    chk("clean_err", line_err, 0);
    chk("clean_abort", n_ab - s_ab, 0);
    chk("clean_top", n_top - s_top, 7);
    chk("clean_left", n_left - s_left, 3);
    chk("clean_bot_right", (n_bot - s_bot) + (n_right - s_right), 0);
    chk("edge_gated", n_edge_bad, 0);

    // 1-of-3 clken duty
    snap();
    vsync = 1'b1;
    for (int l = 0; l < 4; l++) send_line(8, 2);
    end_frame();
    check_full("gap");
    chk("gap_win_on_accept", n_win_bad, 0);

    // short row 2
    snap();
    vsync = 1'b1;
    send_line(8, 0);
    send_line(8, 0);
    chk("short_err_before", line_err, 0);
    send_line(6, 0);
    chk("short_err_after", line_err, 1);
    send_line(8, 0);
    end_frame();
    chk("short_clken", n_clk - s_clk, 30);
    chk("short_win", n_win - s_win, 19);
    chk("short_fd", n_fd - s_fd, 1);
    chk("short_err_sticky", line_err, 1);

    // next frame clears the error, then row 1 is overlong
    snap();
    vsync = 1'b1;
    send_line(8, 0);
    chk("err_cleared", line_err, 0);
    s_win = n_clk;
    send_line(10, 0);
    chk("long_clken", n_clk - s_win, 8);
    chk("long_err", line_err, 1);
    chk("long_col", col_cnt, 7);
    chk("long_row", row_cnt, 1);
    send_line(8, 0);
    send_line(8, 0);
    end_frame();
    chk("long_frame_clken", n_clk - s_clk, 32);
    chk("long_fd", n_fd - s_fd, 1);

    // vsync falls during row 2
    snap();
    vsync = 1'b1;
    send_line(8, 0);
    send_line(8, 0);
    hsync = 1'b1;
    for (int i = 0; i < 3; i++) begin clken = 1'b1; tick(); end
    clken = 1'b0; hsync = 1'b0; vsync = 1'b0;
    tick();
    chk("abort_pulse", frame_abort, 1);
    tick();
    chk("abort_one_cycle", frame_abort, 0);
    chk("abort_count", n_ab - s_ab, 1);
    chk("abort_no_done", n_fd - s_fd, 0);
    snap();
    vsync = 1'b1;
    send_line(8, 0);
    chk("restart_row", row_cnt, 0);
    for (int l = 0; l < 3; l++) send_line(8, 0);
    end_frame();
    check_full("restart");

    // reset in the middle of row 1
    vsync = 1'b1;
    send_line(8, 0);
    hsync = 1'b1;
    for (int i = 0; i < 3; i++) begin clken = 1'b1; tick(); end
    rst = 1'b1;
    tick();
    chk("midrst_outs", {line_clken, line_hsync, col_cnt, row_cnt, win_valid,
                        edge_top, edge_bot, edge_left, edge_right,
                        frame_start, frame_done, frame_abort, line_err}, 0);
    clken = 1'b0; hsync = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    snap();
    send_line(8, 0);
    chk("no_fresh_rise", n_clk - s_clk, 0);
    end_frame();
    snap();
    vsync = 1'b1;
    for (int l = 0; l < 4; l++) send_line(8, 0);
    end_frame();
    check_full("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
